// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded general register file.
package regfile_pkg;

    localparam int unsigned ZERO_REG    = 0;
    localparam int unsigned MAX_BUS_W   = 256;
    localparam int unsigned MAX_FIELD_W = 64;

    // Field k of width w from a flattened bus, zero-extended to MAX_FIELD_W.
    function automatic logic [MAX_FIELD_W-1:0] get_field(input logic [MAX_BUS_W-1:0] bus,
                                                         input int unsigned k,
                                                         input int unsigned w);
        logic [MAX_BUS_W-1:0] mask;
        mask = {MAX_BUS_W{1'b1}} >> (MAX_BUS_W - w);
        return MAX_FIELD_W'((bus >> (k * w)) & mask);
    endfunction

    // Largest value a pending-write counter may hold.
    function automatic int unsigned cnt_sat(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// Pending-write counter for one register: +1 on issue, -0/1/2 on write-back, floors at 0.
module regfile_sb_cnt
    import regfile_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum = {1'b0, cnt_q} + (CNT_W + 1)'(inc);
        // Unscoreboarded write-backs are legal, so the counter floors at zero.
        if (sum >= (CNT_W + 1)'(dec)) begin
            cnt_d = CNT_W'(sum - (CNT_W + 1)'(dec));
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign sat  = (cnt_q == CNT_W'(cnt_sat(CNT_W)));
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with two write-back ports, bypass and a pending-write scoreboard.
// Optional macro GRF_TRACE_EN prints every committed non-zero write.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rready,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_ok,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [31:0]           wpc1,
    input  logic [31:0]           wpc0
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [CNT_W-1:0]  cnt_all  [DEPTH];
    logic              sat_all  [DEPTH];
    logic              zero_all [DEPTH];
    logic [1:0]        dec_all  [DEPTH];
    logic [ADDR_W-1:0] raddr_k  [NRD];

    // Storage: port 1 is applied last so it wins a collision.
    always_comb begin
        regs_d = regs_q;
        if (we0 && waddr0 != ZERO_ADDR) begin
            regs_d[waddr0] = wdata0;
        end
        if (we1 && waddr1 != ZERO_ADDR) begin
            regs_d[waddr1] = wdata1;
        end
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            dec_all[r] = 2'(we0 && waddr0 == ADDR_W'(r)) + 2'(we1 && waddr1 == ADDR_W'(r));
        end
    end

    assign iss_ok = iss_en && (iss_addr == ZERO_ADDR || !sat_all[iss_addr]);

    // Register 0 is hardwired, so it carries no counter.
    assign cnt_all[0]  = '0;
    assign sat_all[0]  = 1'b0;
    assign zero_all[0] = 1'b1;

    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        regfile_sb_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .reset(reset),
            .inc  (iss_ok && iss_addr == ADDR_W'(r)),
            .dec  (dec_all[r]),
            .cnt  (cnt_all[r]),
            .sat  (sat_all[r]),
            .zero (zero_all[r])
        );
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            raddr_k[k] = ADDR_W'(get_field(MAX_BUS_W'(raddr), k, ADDR_W));
        end
    end

    always_comb begin
        rdata  = '0;
        rready = '0;
        for (int k = 0; k < NRD; k++) begin
            if (raddr_k[k] == ZERO_ADDR) begin
                rdata[k*DATA_W +: DATA_W] = '0;
            end else if (we1 && waddr1 == raddr_k[k]) begin
                rdata[k*DATA_W +: DATA_W] = wdata1;
            end else if (we0 && waddr0 == raddr_k[k]) begin
                rdata[k*DATA_W +: DATA_W] = wdata0;
            end else begin
                rdata[k*DATA_W +: DATA_W] = regs_q[raddr_k[k]];
            end
            // A write-back draining the last pending write is ready via the bypass.
            rready[k] = (raddr_k[k] == ZERO_ADDR) || zero_all[raddr_k[k]] ||
                        (32'(cnt_all[raddr_k[k]]) <= 32'(dec_all[raddr_k[k]]));
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (we0 && waddr0 != ZERO_ADDR && !(we1 && waddr1 == waddr0)) begin
                $display("@%h: $%0d <= %h", wpc0, waddr0, wdata0);
            end
            if (we1 && waddr1 != ZERO_ADDR) begin
                $display("@%h: $%0d <= %h", wpc1, waddr1, wdata1);
            end
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^{wpc0, wpc1};
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with default parameters.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int CNT_W  = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rready;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_ok;
    logic                  we0, we1;
    logic [ADDR_W-1:0]     waddr0, waddr1;
    logic [DATA_W-1:0]     wdata0, wdata1;
    logic [31:0]           wpc0, wpc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NRD   (NRD),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raddr   (raddr),
        .rdata   (rdata),
        .rready  (rready),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .iss_ok  (iss_ok),
        .we0     (we0),
        .waddr0  (waddr0),
        .wdata0  (wdata0),
        .we1     (we1),
        .waddr1  (waddr1),
        .wdata1  (wdata1),
        .wpc1    (wpc1),
        .wpc0    (wpc0)
    );

    task automatic idle();
        iss_en = 1'b0; iss_addr = '0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0; wpc0 = 32'h0000_1000;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0; wpc1 = 32'h0000_1004;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic test_reset();
        idle();
        set_raddr(5'd0, 5'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            set_raddr(5'(r), 5'(r));
            #1;
            checks++;
            if (rdata !== 64'h0) begin
                errors++;
                $display("FAIL reset_rdata r=%0d: got %h expected 0", r, rdata);
            end
            checks++;
            if (rready !== 2'b11) begin
                errors++;
                $display("FAIL reset_rready r=%0d: got %b expected 11", r, rready);
            end
        end
        iss_en = 1'b1; iss_addr = 5'd1;
        #1;
        checks++;
        if (iss_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_iss_ok: got %b expected 1", iss_ok);
        end
        iss_en = 1'b0;
        #1;
        checks++;
        if (iss_ok !== 1'b0) begin
            errors++;
            $display("FAIL iss_ok_idle: got %b expected 0", iss_ok);
        end
    endtask

    task automatic test_bypass();
        idle();
        set_raddr(5'd5, 5'd6);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_p0: got %h expected deadbeef", rdata[31:0]);
        end
        checks++;
        if (rdata[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL bypass_other: got %h expected 0", rdata[63:32]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL stored_5: got %h expected deadbeef", rdata[31:0]);
        end
        // Port 1 bypass on read port 1.
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h0000_0ABC;
        #1;
        checks++;
        if (rdata[63:32] !== 32'h0000_0ABC) begin
            errors++;
            $display("FAIL bypass_p1: got %h expected 00000abc", rdata[63:32]);
        end
        tick();
        idle();
    endtask

    task automatic test_collision();
        idle();
        set_raddr(5'd7, 5'd7);
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        #1;
        checks++;
        if (rdata !== {32'h22, 32'h22}) begin
            errors++;
            $display("FAIL collide_bypass: got %h expected both 22", rdata);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata[31:0] !== 32'h22) begin
            errors++;
            $display("FAIL collide_stored: got %h expected 22", rdata[31:0]);
        end
        set_raddr(5'd0, 5'd0);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
        #1;
        checks++;
        if (rdata !== 64'h0 || rready !== 2'b11) begin
            errors++;
            $display("FAIL zero_write_bypass: got %h/%b expected 0/11", rdata, rready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL zero_write_stored: got %h expected 0", rdata);
        end
    endtask

    task automatic test_saturation();
        idle();
        set_raddr(5'd3, 5'd3);
        for (int i = 0; i < 3; i++) begin
            iss_en = 1'b1; iss_addr = 5'd3;
            #1;
            checks++;
            if (iss_ok !== 1'b1) begin
                errors++;
                $display("FAIL sat_issue_%0d: got %b expected 1", i, iss_ok);
            end
            tick();
        end
        #1;
        checks++;
        if (iss_ok !== 1'b0) begin
            errors++;
            $display("FAIL sat_refused: got %b expected 0", iss_ok);
        end
        checks++;
        if (rready !== 2'b00) begin
            errors++;
            $display("FAIL sat_pending: got %b expected 00", rready);
        end
        tick();
        iss_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h100 + 32'(i);
            #1;
            checks++;
            if (rready !== ((i == 2) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL sat_wb_ready_%0d: got %b expected %b", i, rready,
                         (i == 2) ? 2'b11 : 2'b00);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (rready !== 2'b11 || rdata[31:0] !== 32'h102) begin
            errors++;
            $display("FAIL sat_drained: got %b/%h expected 11/102", rready, rdata[31:0]);
        end
    endtask

    task automatic test_net_and_underflow();
        idle();
        set_raddr(5'd9, 5'd4);
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        iss_en = 1'b1; iss_addr = 5'd9;
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
        tick();
        idle();
        #1;
        checks++;
        if (rready[0] !== 1'b0) begin
            errors++;
            $display("FAIL net_pending: got %b expected 0", rready[0]);
        end
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h9A;
        #1;
        checks++;
        if (rready[0] !== 1'b1 || rdata[31:0] !== 32'h9A) begin
            errors++;
            $display("FAIL net_final_wb: got %b/%h expected 1/9a", rready[0], rdata[31:0]);
        end
        tick();
        idle();
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
        tick();
        idle();
        #1;
        checks++;
        if (rdata[63:32] !== 32'h44 || rready !== 2'b11) begin
            errors++;
            $display("FAIL underflow_store: got %h/%b expected 44/11", rdata[63:32], rready);
        end
        // Counter must have stayed 0: one issue then one write-back drains it.
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        #1;
        checks++;
        if (rready[1] !== 1'b0) begin
            errors++;
            $display("FAIL underflow_reissue: got %b expected 0", rready[1]);
        end
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h45;
        tick();
        idle();
        #1;
        checks++;
        if (rready[1] !== 1'b1 || rdata[63:32] !== 32'h45) begin
            errors++;
            $display("FAIL underflow_drain: got %b/%h expected 1/45", rready[1], rdata[63:32]);
        end
    endtask

    task automatic test_reset_midflight();
        idle();
        set_raddr(5'd10, 5'd5);
        for (int i = 0; i < 2; i++) begin
            iss_en = 1'b1; iss_addr = 5'd10;
            tick();
        end
        idle();
        #1;
        checks++;
        if (rready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_pending: got %b expected 0", rready[0]);
        end
        reset = 1'b1;
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h77;
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (rdata !== 64'h0 || rready !== 2'b11) begin
            errors++;
            $display("FAIL mid_after_reset: got %h/%b expected 0/11", rdata, rready);
        end
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h5;
        tick();
        idle();
        #1;
        checks++;
        if (rdata[31:0] !== 32'h5 || rready[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_late_wb: got %h/%b expected 5/1", rdata[31:0], rready[0]);
        end
        iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        idle();
        #1;
        checks++;
        if (rready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_counter_zero: got %b expected 0", rready[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        raddr = '0;
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_saturation();
        test_net_and_underflow();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
